// File: rtl/fifo_wr_pkg.sv
// Shared types and helpers for the write-domain serializer of the async FIFO.
package fifo_wr_pkg;

  // Widest keep mask the lane picker handles.
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    TRAIL = 2'd2
  } ser_state_e;

  // Number of FIFO-width lanes in one producer word.
  function automatic int lanes(input int in_w, input int out_w);
    return in_w / out_w;
  endfunction

  // Index of the lowest set bit; 0 when the mask is empty.
  function automatic int lowest_set_idx(input logic [MAX_LANES-1:0] mask);
    int idx;
    idx = 0;
    for (int i = MAX_LANES - 1; i >= 0; i--) begin
      if (mask[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_wr_serializer.sv
// Write-side front end of the async FIFO: takes wide keep/last words and
// writes the kept lanes LSB-first, optionally followed by a lane-count trailer.
module fifo_wr_serializer
  import fifo_wr_pkg::*;
#(
  parameter  int IN_W        = 32,
  parameter  int OUT_W       = 8,
  parameter  int TRAILER_EN  = 1,
  parameter  int FCNT_W      = 16,
  parameter  int FIFO_DATA_W = OUT_W,
  localparam int LANES       = lanes(IN_W, OUT_W)
) (
  input  logic              wclk,
  input  logic              wrst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [IN_W-1:0]   s_data,
  input  logic [LANES-1:0]  s_keep,
  input  logic              s_last,
  output logic              fifo_wen,
  output logic [OUT_W-1:0]  fifo_wdata,
  input  logic              fifo_wfull,
  output logic              busy,
  output logic [FCNT_W-1:0] frames_done
);

  localparam int LIDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam bit TRL    = (TRAILER_EN != 0);

  if ((IN_W % OUT_W) != 0 || OUT_W != FIFO_DATA_W || LANES > MAX_LANES) begin : g_bad_cfg
    $error("fifo_wr_serializer: IN_W must be a multiple of OUT_W and OUT_W must match the FIFO width");
  end

  ser_state_e          r_state;
  ser_state_e          w_state_nxt;
  logic [IN_W-1:0]     r_data;
  logic [LANES-1:0]    r_mask;
  logic [LANES-1:0]    w_mask_nxt;
  logic [LANES-1:0]    w_mask_clr;
  logic                r_last;
  logic [OUT_W-1:0]    r_bcnt;
  logic [OUT_W-1:0]    w_bcnt_nxt;
  logic [FCNT_W-1:0]   r_frames;
  logic [FCNT_W-1:0]   w_frames_nxt;
  logic [OUT_W-1:0]    w_lanes [LANES];
  logic [MAX_LANES-1:0] w_mask_ext;
  logic [LIDX_W-1:0]   w_idx;
  logic                w_wen;
  logic                w_wr_send;
  logic                w_wr_trail;
  logic                w_final;
  logic                w_ready;
  logic                w_accept;
  logic                w_end_cur;
  logic                w_end_new;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = r_data[g*OUT_W +: OUT_W];
  end

  // Pick the lowest remaining lane and the mask left after writing it.
  always_comb begin
    w_mask_ext             = '0;
    w_mask_ext[LANES-1:0]  = r_mask;
    w_idx                  = LIDX_W'(lowest_set_idx(w_mask_ext));
    w_mask_clr             = r_mask & ~(LANES'(1) << w_idx);
  end

  // A write happens whenever something is pending and the FIFO has room.
  assign w_wen      = ((r_state == SEND) || (r_state == TRAIL)) && !fifo_wfull;
  assign w_wr_send  = w_wen && (r_state == SEND);
  assign w_wr_trail = w_wen && (r_state == TRAIL);
  assign w_final    = w_wr_send && (w_mask_clr == '0);
  // Ready reopens in the cycle the held word is finished, so words stream without a bubble.
  assign w_ready    = (r_state == IDLE) || (w_final && !(r_last && TRL)) || w_wr_trail;
  assign w_accept   = s_valid && w_ready;
  // Frame completion from the held word, and from an accepted empty last word with no trailer.
  assign w_end_cur  = w_wr_trail || (w_final && r_last && !TRL);
  assign w_end_new  = w_accept && (s_keep == '0) && s_last && !TRL;

  assign s_ready     = w_ready;
  assign fifo_wen    = w_wen;
  assign busy        = (r_state != IDLE);
  assign frames_done = r_frames;

  // Write data: current lane while sending, lane count while trailing.
  always_comb begin
    fifo_wdata = '0;
    case (r_state)
      SEND:    fifo_wdata = w_lanes[w_idx];
      TRAIL:   fifo_wdata = r_bcnt;
      default: fifo_wdata = '0;
    endcase
  end

  // Next-state, mask, byte counter and frame counter.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    if (w_wr_send)  w_mask_nxt  = w_mask_clr;
    if (w_final)    w_state_nxt = (r_last && TRL) ? TRAIL : IDLE;
    if (w_wr_trail) w_state_nxt = IDLE;
    if (w_accept) begin
      w_mask_nxt = s_keep;
      if (s_keep != '0)        w_state_nxt = SEND;
      else if (s_last && TRL)  w_state_nxt = TRAIL;
      else                     w_state_nxt = IDLE;
    end
    w_bcnt_nxt = w_wr_send ? (r_bcnt + OUT_W'(1)) : r_bcnt;
    if (w_end_cur || w_end_new) w_bcnt_nxt = '0;
    w_frames_nxt = r_frames + FCNT_W'(w_end_cur) + FCNT_W'(w_end_new);
  end

  // State and holding registers; a reset drops any partial frame.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_state  <= IDLE;
      r_data   <= '0;
      r_mask   <= '0;
      r_last   <= 1'b0;
      r_bcnt   <= '0;
      r_frames <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mask   <= w_mask_nxt;
      r_bcnt   <= w_bcnt_nxt;
      r_frames <= w_frames_nxt;
      if (w_accept) begin
        r_data <= s_data;
        r_last <= s_last;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_serializer.sv
// Directed bench for fifo_wr_serializer: a trailer build and a no-trailer build.
module tb_fifo_wr_serializer;

  logic        wclk = 1'b0;
  logic        wrst_n;
  logic        s_valid, s_ready, s_last, fifo_wen, fifo_wfull, busy;
  logic [31:0] s_data;
  logic [3:0]  s_keep;
  logic [7:0]  fifo_wdata;
  logic [15:0] frames_done;

  logic        t0_valid, t0_ready, t0_last, t0_wen, t0_wfull, t0_busy;
  logic [31:0] t0_data;
  logic [3:0]  t0_keep;
  logic [7:0]  t0_wdata;
  logic [15:0] t0_frames;

  int total = 0;
  int bad   = 0;

  always #5 wclk = ~wclk;

  fifo_wr_serializer #(.IN_W(32), .OUT_W(8), .TRAILER_EN(1), .FCNT_W(16)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_keep(s_keep), .s_last(s_last), .fifo_wen(fifo_wen),
    .fifo_wdata(fifo_wdata), .fifo_wfull(fifo_wfull), .busy(busy),
    .frames_done(frames_done)
  );

  fifo_wr_serializer #(.IN_W(32), .OUT_W(8), .TRAILER_EN(0), .FCNT_W(16)) dut0 (
    .wclk(wclk), .wrst_n(wrst_n), .s_valid(t0_valid), .s_ready(t0_ready),
    .s_data(t0_data), .s_keep(t0_keep), .s_last(t0_last), .fifo_wen(t0_wen),
    .fifo_wdata(t0_wdata), .fifo_wfull(t0_wfull), .busy(t0_busy),
    .frames_done(t0_frames)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  // Present one word on the trailer build; it is accepted at the next edge.
  task automatic put(input logic [31:0] d, input logic [3:0] k, input logic l);
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    #1;
    chk("put_ready", {31'b0, s_ready}, 32'd1);
    tick();
    s_valid = 1'b0; s_data = 'x; s_keep = 'x; s_last = 1'b0;
  endtask

  // Expect one FIFO write of value d in the current cycle.
  task automatic wr(input string tag, input logic [7:0] d);
    #1;
    chk({tag, "_wen"},  {31'b0, fifo_wen}, 32'd1);
    chk({tag, "_data"}, {24'b0, fifo_wdata}, {24'b0, d});
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [31:0] w1;
    logic [31:0] w2;
    wrst_n = 1'b1; fifo_wfull = 1'b0;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
    t0_valid = 1'b0; t0_data = '0; t0_keep = '0; t0_last = 1'b0; t0_wfull = 1'b0;
    #1 wrst_n = 1'b0;
    #2;
    // reset state
    chk("rst_ready", {31'b0, s_ready}, 32'd1);
    chk("rst_wen",   {31'b0, fifo_wen}, 32'd0);
    chk("rst_wdata", {24'b0, fifo_wdata}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_frames", {16'b0, frames_done}, 32'd0);
    tick();
    wrst_n = 1'b1;
    tick();

    // full-keep word with trailer
    put(32'h44332211, 4'hF, 1'b1);
    #1;
    chk("t1_busy",  {31'b0, busy}, 32'd1);
    chk("t1_ready", {31'b0, s_ready}, 32'd0);
    wr("t1_l0", 8'h11); wr("t1_l1", 8'h22); wr("t1_l2", 8'h33);
    wr("t1_l3", 8'h44); wr("t1_trl", 8'h04);
    #1;
    chk("t1_frames", {16'b0, frames_done}, 32'd1);
    chk("t1_busy_after", {31'b0, busy}, 32'd0);
    chk("t1_wen_after", {31'b0, fifo_wen}, 32'd0);
    chk("t1_wdata_idle", {24'b0, fifo_wdata}, 32'd0);

    // sparse keep
    put(32'hDDCCBBAA, 4'b1010, 1'b1);
    wr("t2_l1", 8'hBB); wr("t2_l3", 8'hDD); wr("t2_trl", 8'h02);
    #1 chk("t2_frames", {16'b0, frames_done}, 32'd2);

    // empty word: trailer only
    put(32'h0, 4'b0000, 1'b1);
    wr("t3_trl", 8'h00);
    #1 chk("t3_frames", {16'b0, frames_done}, 32'd3);

    // back-to-back words with valid held
    w1 = 32'h44332211;
    w2 = 32'h88776655;
    s_valid = 1'b1; s_data = w1; s_keep = 4'hF; s_last = 1'b0;
    #1 chk("b2b_ready_idle", {31'b0, s_ready}, 32'd1);
    tick();
    s_data = w2; s_last = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("b2b_w1_wen",   {31'b0, fifo_wen}, 32'd1);
      chk("b2b_w1_data",  {24'b0, fifo_wdata}, {24'b0, w1[8*j +: 8]});
      chk("b2b_w1_ready", {31'b0, s_ready}, (j == 3) ? 32'd1 : 32'd0);
      tick();
    end
    s_valid = 1'b0; s_data = 'x; s_keep = 'x; s_last = 1'b0;
    wr("b2b_l4", 8'h55); wr("b2b_l5", 8'h66); wr("b2b_l6", 8'h77);
    wr("b2b_l7", 8'h88); wr("b2b_trl", 8'h08);
    #1 chk("b2b_frames", {16'b0, frames_done}, 32'd4);

    // backpressure for four cycles in the middle of a frame
    put(32'h44332211, 4'hF, 1'b1);
    wr("bp_l0", 8'h11);
    fifo_wfull = 1'b1;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("bp_wen",   {31'b0, fifo_wen}, 32'd0);
      chk("bp_wdata", {24'b0, fifo_wdata}, 32'h22);
      chk("bp_ready", {31'b0, s_ready}, 32'd0);
      tick();
    end
    fifo_wfull = 1'b0;
    wr("bp_l1", 8'h22); wr("bp_l2", 8'h33); wr("bp_l3", 8'h44); wr("bp_trl", 8'h04);
    #1 chk("bp_frames", {16'b0, frames_done}, 32'd5);

    // 257-byte frame wraps the trailer count to 1
    for (int i = 0; i < 64; i++) begin
      put(32'h04030201, 4'hF, 1'b0);
      wr("wrap_a", 8'h01); wr("wrap_b", 8'h02); wr("wrap_c", 8'h03); wr("wrap_d", 8'h04);
    end
    put(32'h000000AB, 4'b0001, 1'b1);
    wr("wrap_last", 8'hAB);
    wr("wrap_trl", 8'h01);
    #1 chk("wrap_frames", {16'b0, frames_done}, 32'd6);

    // reset two lanes into a frame
    put(32'h44332211, 4'hF, 1'b1);
    wr("mr_l0", 8'h11); wr("mr_l1", 8'h22);
    wrst_n = 1'b0;
    #1;
    chk("mr_ready",  {31'b0, s_ready}, 32'd1);
    chk("mr_wen",    {31'b0, fifo_wen}, 32'd0);
    chk("mr_frames", {16'b0, frames_done}, 32'd0);
    chk("mr_busy",   {31'b0, busy}, 32'd0);
    chk("mr_wdata",  {24'b0, fifo_wdata}, 32'd0);
    tick();
    chk("mr_wen_held", {31'b0, fifo_wen}, 32'd0);
    wrst_n = 1'b1;
    tick();
    chk("mr_no_trailer", {31'b0, fifo_wen}, 32'd0);
    put(32'h0000005A, 4'b0001, 1'b1);
    wr("mr_new_l0", 8'h5A);
    wr("mr_new_trl", 8'h01);
    #1 chk("mr_new_frames", {16'b0, frames_done}, 32'd1);

    // no-trailer build
    w1 = 32'h44332211;
    t0_valid = 1'b1; t0_data = w1; t0_keep = 4'hF; t0_last = 1'b1;
    #1 chk("nt_ready", {31'b0, t0_ready}, 32'd1);
    tick();
    t0_valid = 1'b0; t0_data = 'x; t0_keep = 'x; t0_last = 1'b0;
    for (int j = 0; j < 4; j++) begin
      #1;
      chk("nt_wen",  {31'b0, t0_wen}, 32'd1);
      chk("nt_data", {24'b0, t0_wdata}, {24'b0, w1[8*j +: 8]});
      tick();
    end
    #1;
    chk("nt_no_trailer", {31'b0, t0_wen}, 32'd0);
    chk("nt_frames", {16'b0, t0_frames}, 32'd1);
    chk("nt_busy",   {31'b0, t0_busy}, 32'd0);
    t0_valid = 1'b1; t0_data = 32'h0; t0_keep = 4'b0000; t0_last = 1'b1;
    #1 chk("nt_empty_ready", {31'b0, t0_ready}, 32'd1);
    tick();
    t0_valid = 1'b0; t0_last = 1'b0;
    #1;
    chk("nt_empty_frames", {16'b0, t0_frames}, 32'd2);
    chk("nt_empty_wen",    {31'b0, t0_wen}, 32'd0);
    chk("nt_empty_busy",   {31'b0, t0_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
